sass_key_conditioner: RTL and testbench

Input conditioning stage of the SaSS synth, directly upstream of the synth core's voice and sequencer logic. Synchronises and debounces the 15 piano-key inputs and three control buttons taken from the breakout pins. Produces clean held-key levels, single-cycle button press pulses and one monophonic note selection with note-on and note-off strobes for the oscillator and sequencer.

---
 rtl/sass_pkg.sv | 28 ++
 rtl/sass_debounce.sv | 36 +++
 rtl/sass_key_conditioner.sv | 116 +++++++++++
 tb/tb_sass_key_conditioner.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sass_pkg.sv
// Shared types and constants for the SaSS key conditioning path.
package sass_pkg;

    localparam int NUM_KEYS = 15;
    localparam int NUM_BTNS = 3;

    localparam int BTN_POWER = 0;
    localparam int BTN_TEMPO = 1;
    localparam int BTN_PLAY  = 2;

    typedef logic [3:0] note_idx_t;

    typedef struct packed {
        logic      valid;
        note_idx_t idx;
    } note_sel_t;

    // Lowest set bit wins; returns 0 for an empty vector.
    function automatic note_idx_t lowest_idx(input logic [NUM_KEYS-1:0] v);
        note_idx_t r;
        r = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) r = note_idx_t'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/sass_debounce.sv
// One input: 2-flop synchroniser, tick-sampled history and debounced level.
module sass_debounce #(
    parameter int STABLE_SAMPLES = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic raw,
    input  logic tick,
    output logic level
);

    logic [1:0]                sync;
    logic [STABLE_SAMPLES-1:0] hist;
    logic [STABLE_SAMPLES-1:0] hist_nxt;

    // The freshly shifted sample counts toward the stability decision.
    assign hist_nxt = {hist[STABLE_SAMPLES-2:0], sync[1]};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync  <= '0;
            hist  <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (tick) begin
                hist <= hist_nxt;
                if ((&hist_nxt) && !level)
                    level <= 1'b1;
                else if (!(|hist_nxt) && level)
                    level <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sass_key_conditioner.sv
// Key/button conditioning: debounce, button press pulses, monophonic note select.
// Optional SASS_LAST_NOTE_PRIORITY_EN selects last-pressed priority instead of lowest index.
module sass_key_conditioner
    import sass_pkg::*;
#(
    parameter int TICK_DIV       = 1000,
    parameter int STABLE_SAMPLES = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NUM_KEYS-1:0] piano_keys,
    input  logic [NUM_BTNS-1:0] btn_raw,
    output logic [NUM_KEYS-1:0] keys_held,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic                note_valid,
    output note_idx_t           note_idx,
    output logic                note_on,
    output logic                note_off
);

    localparam int NUM_IN = NUM_KEYS + NUM_BTNS;
    localparam int CNT_W  = $clog2(TICK_DIV);

    logic [CNT_W-1:0]    cnt;
    logic                tick;
    logic [NUM_IN-1:0]   raw_all;
    logic [NUM_IN-1:0]   lvl_all;
    logic [NUM_BTNS-1:0] btn_lvl;
    logic [NUM_BTNS-1:0] btn_prev;
    note_sel_t           cand;

    assign tick = (cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign raw_all = {btn_raw, piano_keys};

    for (genvar g = 0; g < NUM_IN; g++) begin : g_deb
        sass_debounce #(
            .STABLE_SAMPLES(STABLE_SAMPLES)
        ) u_deb (
            .clk  (clk),
            .n_rst(n_rst),
            .raw  (raw_all[g]),
            .tick (tick),
            .level(lvl_all[g])
        );
    end

    assign keys_held = lvl_all[NUM_KEYS-1:0];
    assign btn_lvl   = lvl_all[NUM_KEYS +: NUM_BTNS];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            btn_prev  <= '0;
            btn_press <= '0;
        end else begin
            btn_prev  <= btn_lvl;
            btn_press <= btn_lvl & ~btn_prev;
        end
    end

`ifdef SASS_LAST_NOTE_PRIORITY_EN
    logic [NUM_KEYS-1:0] keys_prev;
    logic [NUM_KEYS-1:0] fresh;
    logic [15:0]         held_ext;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            keys_prev <= '0;
        else
            keys_prev <= keys_held;
    end

    assign fresh    = keys_held & ~keys_prev;
    assign held_ext = {{(16 - NUM_KEYS){1'b0}}, keys_held};

    // Newest press wins; keep current note while held; otherwise fall back to lowest.
    always_comb begin
        cand.valid = |keys_held;
        cand.idx   = lowest_idx(keys_held);
        if (|fresh)
            cand.idx = lowest_idx(fresh);
        else if (note_valid && held_ext[note_idx])
            cand.idx = note_idx;
    end
`else
    always_comb begin
        cand.valid = |keys_held;
        cand.idx   = lowest_idx(keys_held);
    end
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            note_valid <= 1'b0;
            note_idx   <= '0;
            note_on    <= 1'b0;
            note_off   <= 1'b0;
        end else begin
            note_valid <= cand.valid;
            note_on    <= cand.valid && (!note_valid || (cand.idx != note_idx));
            note_off   <= note_valid && !cand.valid;
            if (cand.valid)
                note_idx <= cand.idx;
        end
    end

endmodule

// File: tb/tb_sass_key_conditioner.sv
// Directed bench for sass_key_conditioner with TICK_DIV=4, STABLE_SAMPLES=3.
module tb_sass_key_conditioner;
    import sass_pkg::*;

    logic                clk = 1'b0;
    logic                n_rst = 1'b0;
    logic [NUM_KEYS-1:0] piano_keys = '0;
    logic [NUM_BTNS-1:0] btn_raw = '0;
    logic [NUM_KEYS-1:0] keys_held;
    logic [NUM_BTNS-1:0] btn_press;
    logic                note_valid;
    note_idx_t           note_idx;
    logic                note_on;
    logic                note_off;

    int n_cmp = 0;
    int n_err = 0;

    int          on_cnt = 0;
    int          off_cnt = 0;
    int          both_cnt = 0;
    int          btn_cnt [NUM_BTNS] = '{0, 0, 0};
    note_idx_t   on_idx = '0;
    int unsigned cyc;

    sass_key_conditioner #(
        .TICK_DIV      (4),
        .STABLE_SAMPLES(3)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .piano_keys(piano_keys),
        .btn_raw   (btn_raw),
        .keys_held (keys_held),
        .btn_press (btn_press),
        .note_valid(note_valid),
        .note_idx  (note_idx),
        .note_on   (note_on),
        .note_off  (note_off)
    );

    always #5 clk = ~clk;

    // Strobe monitor: counts every one-cycle pulse.
    always @(negedge clk) begin
        if (note_on) begin
            on_cnt = on_cnt + 1;
            on_idx = note_idx;
        end
        if (note_off) off_cnt = off_cnt + 1;
        if (note_on && note_off) both_cnt = both_cnt + 1;
        for (int b = 0; b < NUM_BTNS; b++)
            if (btn_press[b]) btn_cnt[b] = btn_cnt[b] + 1;
    end

    // Cycles since reset release; prescaler phase is cyc mod 4.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_keys(input logic [NUM_KEYS-1:0] k);
        @(negedge clk);
        piano_keys = k;
    endtask

    task automatic test_reset;
        int on0, off0, n;
        int b0 [NUM_BTNS];
        n_rst = 1'b0;
        piano_keys = '1;
        btn_raw = '1;
        step(5);
        n_cmp++;
        if ({keys_held, btn_press, note_valid, note_idx, note_on, note_off} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got keys=%h btn=%b nv=%b idx=%0d on=%b off=%b, want all 0",
                     keys_held, btn_press, note_valid, note_idx, note_on, note_off);
        end
        on0 = on_cnt;
        for (int b = 0; b < NUM_BTNS; b++) b0[b] = btn_cnt[b];
        @(negedge clk);
        n_rst = 1'b1;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (keys_held == 15'h7FFF) begin
                n = i;
                break;
            end
        end
        n_cmp++;
        if (n < 1 || n > 15) begin
            n_err++;
            $display("FAIL reset_accept_latency: got %0d cycles (0=never), want 1..15", n);
        end
        step(4);
        n_cmp++;
        if (note_idx !== 4'd0 || note_valid !== 1'b1) begin
            n_err++;
            $display("FAIL reset_note: got idx=%0d nv=%b, want idx=0 nv=1", note_idx, note_valid);
        end
        n_cmp++;
        if (on_cnt - on0 !== 1) begin
            n_err++;
            $display("FAIL reset_note_on_count: got %0d, want 1", on_cnt - on0);
        end
        n_cmp++;
        if (btn_cnt[0] - b0[0] !== 1 || btn_cnt[1] - b0[1] !== 1 || btn_cnt[2] - b0[2] !== 1) begin
            n_err++;
            $display("FAIL reset_btn_press: got %0d/%0d/%0d, want 1/1/1",
                     btn_cnt[0] - b0[0], btn_cnt[1] - b0[1], btn_cnt[2] - b0[2]);
        end
        off0 = off_cnt;
        @(negedge clk);
        piano_keys = '0;
        btn_raw = '0;
        step(25);
        n_cmp++;
        if (keys_held !== '0 || off_cnt - off0 !== 1) begin
            n_err++;
            $display("FAIL reset_release: got keys=%h offs=%0d, want keys=0 offs=1", keys_held, off_cnt - off0);
        end
    endtask

    task automatic test_bounce;
        int on0, off0;
        logic early;
        on0 = on_cnt;
        early = 1'b0;
        for (int i = 0; i < 42; i++) begin
            @(negedge clk);
            piano_keys[5] = ((i / 3) % 2) == 0;
            if (keys_held[5]) early = 1'b1;
        end
        n_cmp++;
        if (early !== 1'b0 || on_cnt - on0 !== 0) begin
            n_err++;
            $display("FAIL bounce_rejected: got early=%b ons=%0d, want early=0 ons=0", early, on_cnt - on0);
        end
        @(negedge clk);
        piano_keys[5] = 1'b1;
        step(25);
        n_cmp++;
        if (keys_held !== 15'h0020) begin
            n_err++;
            $display("FAIL bounce_steady_level: got %h, want 0020", keys_held);
        end
        n_cmp++;
        if (on_cnt - on0 !== 1 || on_idx !== 4'd5 || note_idx !== 4'd5) begin
            n_err++;
            $display("FAIL bounce_note_on: got ons=%0d on_idx=%0d idx=%0d, want 1/5/5",
                     on_cnt - on0, on_idx, note_idx);
        end
        off0 = off_cnt;
        set_keys('0);
        step(25);
        n_cmp++;
        if (off_cnt - off0 !== 1 || note_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bounce_release: got offs=%0d nv=%b, want 1/0", off_cnt - off0, note_valid);
        end
    endtask

    task automatic test_priority;
        int on0, off0;
        on0 = on_cnt;
        set_keys(15'h0200);
        step(20);
        n_cmp++;
        if (note_idx !== 4'd9 || on_cnt - on0 !== 1) begin
            n_err++;
            $display("FAIL prio_hold9: got idx=%0d ons=%0d, want 9/1", note_idx, on_cnt - on0);
        end
        on0 = on_cnt;
        set_keys(15'h0208);
        step(20);
        n_cmp++;
        if (note_idx !== 4'd3 || on_cnt - on0 !== 1) begin
            n_err++;
            $display("FAIL prio_press3: got idx=%0d ons=%0d, want 3/1", note_idx, on_cnt - on0);
        end
`ifdef SASS_LAST_NOTE_PRIORITY_EN
        on0 = on_cnt;
        set_keys(15'h1208);
        step(20);
        n_cmp++;
        if (note_idx !== 4'd12 || on_cnt - on0 !== 1) begin
            n_err++;
            $display("FAIL prio_press12: got idx=%0d ons=%0d, want 12/1", note_idx, on_cnt - on0);
        end
        on0 = on_cnt;
        set_keys(15'h0208);
        step(20);
        n_cmp++;
        if (note_idx !== 4'd3 || on_cnt - on0 !== 1) begin
            n_err++;
            $display("FAIL prio_release12: got idx=%0d ons=%0d, want 3/1", note_idx, on_cnt - on0);
        end
`endif
        on0 = on_cnt;
        set_keys(15'h0200);
        step(20);
        n_cmp++;
        if (note_idx !== 4'd9 || on_cnt - on0 !== 1) begin
            n_err++;
            $display("FAIL prio_release3: got idx=%0d ons=%0d, want 9/1", note_idx, on_cnt - on0);
        end
        on0 = on_cnt;
        off0 = off_cnt;
        set_keys('0);
        step(20);
        n_cmp++;
        if (off_cnt - off0 !== 1 || on_cnt - on0 !== 0 || note_idx !== 4'd9 || note_valid !== 1'b0) begin
            n_err++;
            $display("FAIL prio_release9: got offs=%0d ons=%0d idx=%0d nv=%b, want 1/0/9/0",
                     off_cnt - off0, on_cnt - on0, note_idx, note_valid);
        end
    endtask

    task automatic test_button;
        int b0 [NUM_BTNS];
        for (int b = 0; b < NUM_BTNS; b++) b0[b] = btn_cnt[b];
        @(negedge clk);
        btn_raw[BTN_PLAY] = 1'b1;
        step(50);
        n_cmp++;
        if (btn_cnt[BTN_PLAY] - b0[BTN_PLAY] !== 1) begin
            n_err++;
            $display("FAIL btn_play_press: got %0d pulses, want 1", btn_cnt[BTN_PLAY] - b0[BTN_PLAY]);
        end
        n_cmp++;
        if (btn_cnt[BTN_POWER] - b0[BTN_POWER] !== 0 || btn_cnt[BTN_TEMPO] - b0[BTN_TEMPO] !== 0) begin
            n_err++;
            $display("FAIL btn_other_quiet: got power=%0d tempo=%0d, want 0/0",
                     btn_cnt[BTN_POWER] - b0[BTN_POWER], btn_cnt[BTN_TEMPO] - b0[BTN_TEMPO]);
        end
        @(negedge clk);
        btn_raw[BTN_PLAY] = 1'b0;
        step(25);
        n_cmp++;
        if (btn_cnt[BTN_PLAY] - b0[BTN_PLAY] !== 1 || btn_press !== 3'b000) begin
            n_err++;
            $display("FAIL btn_play_release: got %0d pulses press=%b, want 1/000",
                     btn_cnt[BTN_PLAY] - b0[BTN_PLAY], btn_press);
        end
    endtask

    task automatic test_simultaneous;
        int on0, off0;
        on0 = on_cnt;
        off0 = off_cnt;
        set_keys(15'h0084);
        step(20);
        n_cmp++;
        if (keys_held !== 15'h0084 || on_cnt - on0 !== 1 || note_idx !== 4'd2) begin
            n_err++;
            $display("FAIL simul_press: got keys=%h ons=%0d idx=%0d, want 0084/1/2",
                     keys_held, on_cnt - on0, note_idx);
        end
        set_keys('0);
        step(20);
        n_cmp++;
        if (off_cnt - off0 !== 1 || on_cnt - on0 !== 1) begin
            n_err++;
            $display("FAIL simul_release: got offs=%0d ons=%0d, want 1/1", off_cnt - off0, on_cnt - on0);
        end
    endtask

    task automatic test_reset_mid;
        int on0, n;
        set_keys(15'h0010);
        step(20);
        n_cmp++;
        if (note_valid !== 1'b1 || note_idx !== 4'd4) begin
            n_err++;
            $display("FAIL mid_precondition: got nv=%b idx=%0d, want 1/4", note_valid, note_idx);
        end
        do begin
            @(posedge clk);
            #1;
        end while (cyc % 4 != 1);
        @(negedge clk);
        piano_keys[1] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        n_rst = 1'b0;
        #1;
        n_cmp++;
        if ({keys_held, btn_press, note_valid, note_idx, note_on, note_off} !== '0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got keys=%h nv=%b idx=%0d, want all 0",
                     keys_held, note_valid, note_idx);
        end
        step(3);
        on0 = on_cnt;
        @(negedge clk);
        n_rst = 1'b1;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (keys_held[1]) begin
                n = i;
                break;
            end
        end
        n_cmp++;
        if (n !== 12) begin
            n_err++;
            $display("FAIL mid_reaccept_latency: got %0d cycles (0=never), want 12", n);
        end
        step(4);
        n_cmp++;
        if (on_cnt - on0 !== 1 || on_idx !== 4'd1 || keys_held !== 15'h0012) begin
            n_err++;
            $display("FAIL mid_fresh_note_on: got ons=%0d idx=%0d keys=%h, want 1/1/0012",
                     on_cnt - on0, on_idx, keys_held);
        end
        set_keys('0);
        step(20);
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_priority();
        test_button();
        test_simultaneous();
        test_reset_mid();
        n_cmp++;
        if (both_cnt !== 0) begin
            n_err++;
            $display("FAIL strobe_exclusive: got %0d cycles with on&off, want 0", both_cnt);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
